// File: rtl/l1_bus_pkg.sv
// l1_bus_pkg: shared state/owner encodings and default geometry for the L1 bus sequencer.
package l1_bus_pkg;
    localparam int DEF_ADDR_WIDTH = 24;
    localparam int DEF_LINE_WID   = 7;

    typedef enum logic [2:0] {IDLE, GRANT, LINE_RD, LINE_WR, SINGLE, DONE, ERR} state_t;
    typedef enum logic {OWN_CACHE, OWN_DMA} owner_t;
endpackage

// File: rtl/l1_bus_rr_arb.sv
// l1_bus_rr_arb: 2-way round-robin between the cache and DMA; only a contested grant moves the pointer.
module l1_bus_rr_arb
    import l1_bus_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    output logic [1:0] gnt,
    output owner_t     ptr
);
    owner_t ptr_q, ptr_d;

    always_comb begin
        gnt   = &req ? (ptr_q == OWN_DMA ? 2'b10 : 2'b01) : req;
        ptr_d = (upd && &req) ? (gnt[OWN_CACHE] ? OWN_DMA : OWN_CACHE) : ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= OWN_CACHE;
        else     ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;
endmodule

// File: rtl/l1_bus_sequencer.sv
// l1_bus_sequencer: serialises cache line fills, cache single bytes and DMA bytes onto one byte bus.
// Define L1_BUS_TIMEOUT_EN to abort a beat after TIMEOUT cycles without mem_rdy.
module l1_bus_sequencer
    import l1_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LINE_WID   = DEF_LINE_WID,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read_line_req,
    input  logic                  read_req,
    input  logic                  write_through_req,
    input  logic [ADDR_WIDTH-1:0] bus_pa,
    input  logic [7:0]            bus_wdata,
    output logic [7:0]            bus_rdata,
    output logic [LINE_WID:0]     addr_count,
    output logic                  line_write,
    output logic                  bus_trans_finish,
    output logic                  bus_error,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [7:0]            dma_wdata,
    output logic [7:0]            dma_rdata,
    output logic                  dma_ack,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata,
    input  logic                  mem_rdy,
    input  logic                  mem_err
);
    state_t                state_q, state_d;
    owner_t                owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] pa_q, pa_d, mem_addr_q, mem_addr_d;
    logic [7:0]            wd_q, wd_d, mem_wdata_q, mem_wdata_d;
    logic [7:0]            bus_rdata_q, bus_rdata_d, dma_rdata_q, dma_rdata_d;
    logic [LINE_WID:0]     cnt_q, cnt_d;
    logic                  we_q, we_d, mem_cs_q, mem_cs_d, mem_we_q, mem_we_d;
    logic                  lw_q, lw_d, fin_q, fin_d, err_q, err_d, ack_q, ack_d;
    logic [1:0]            rr_req, rr_gnt;
    owner_t                rr_ptr_unused;
    logic                  expired;

    assign rr_req = {dma_req, read_line_req | read_req | write_through_req};

    l1_bus_rr_arb u_arb (
        .clk (clk),
        .rst (rst),
        .req (rr_req),
        .upd (state_q == GRANT),
        .gnt (rr_gnt),
        .ptr (rr_ptr_unused)
    );

`ifdef L1_BUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_q, wait_d;
    // Counter is zero whenever mem_cs was low or a beat just completed.
    assign wait_d  = (mem_cs_q && !mem_rdy) ? wait_q + 1'b1 : '0;
    assign expired = mem_cs_q && !mem_rdy && wait_q == TW'(TIMEOUT - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) wait_q <= '0;
        else     wait_q <= wait_d;
    end
`else
    localparam int timeout_unused = TIMEOUT;
    assign expired = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        pa_d        = pa_q;
        wd_d        = wd_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        bus_rdata_d = bus_rdata_q;
        dma_rdata_d = dma_rdata_q;
        case (state_q)
            IDLE:    state_d = |rr_req ? GRANT : IDLE;
            GRANT: begin
                owner_d = rr_gnt[OWN_DMA] ? OWN_DMA : OWN_CACHE;
                pa_d    = rr_gnt[OWN_DMA] ? dma_addr : bus_pa;
                wd_d    = rr_gnt[OWN_DMA] ? dma_wdata : bus_wdata;
                we_d    = rr_gnt[OWN_DMA] ? dma_we : !read_line_req && !read_req;
                cnt_d   = '0;
                state_d = !(|rr_req) ? IDLE : (rr_gnt[OWN_CACHE] && read_line_req) ? LINE_RD : SINGLE;
            end
            LINE_RD: begin
                if (mem_err || expired) state_d = ERR;
                else if (mem_rdy) begin
                    bus_rdata_d = mem_rdata;
                    state_d     = LINE_WR;
                end
            end
            LINE_WR: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = &cnt_q ? DONE : LINE_RD;
            end
            SINGLE: begin
                if (mem_err || expired) state_d = ERR;
                else if (mem_rdy) begin
                    bus_rdata_d = owner_q == OWN_CACHE ? mem_rdata : bus_rdata_q;
                    dma_rdata_d = owner_q == OWN_DMA ? mem_rdata : dma_rdata_q;
                    state_d     = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Bus-facing outputs are registered off the next state so they align with state_q.
        mem_cs_d    = state_d == LINE_RD || state_d == SINGLE;
        mem_we_d    = state_d == SINGLE && we_d;
        mem_addr_d  = state_d == LINE_RD ? {pa_d[ADDR_WIDTH-1:LINE_WID+1], cnt_d} :
                      state_d == SINGLE  ? pa_d : mem_addr_q;
        mem_wdata_d = state_d == SINGLE ? wd_d : mem_wdata_q;
        lw_d        = state_d == LINE_WR;
        fin_d       = state_d == DONE && owner_d == OWN_CACHE;
        err_d       = state_d == ERR && owner_d == OWN_CACHE;
        ack_d       = (state_d == DONE || state_d == ERR) && owner_d == OWN_DMA;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_CACHE;
            pa_q        <= '0;
            wd_q        <= '0;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            bus_rdata_q <= '0;
            dma_rdata_q <= '0;
            mem_cs_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            lw_q        <= 1'b0;
            fin_q       <= 1'b0;
            err_q       <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            pa_q        <= pa_d;
            wd_q        <= wd_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            bus_rdata_q <= bus_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            mem_cs_q    <= mem_cs_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            lw_q        <= lw_d;
            fin_q       <= fin_d;
            err_q       <= err_d;
            ack_q       <= ack_d;
        end
    end

    assign bus_rdata        = bus_rdata_q;
    assign dma_rdata        = dma_rdata_q;
    assign addr_count       = cnt_q;
    assign line_write       = lw_q;
    assign bus_trans_finish = fin_q;
    assign bus_error        = err_q;
    assign dma_ack          = ack_q;
    assign mem_cs           = mem_cs_q;
    assign mem_we           = mem_we_q;
    assign mem_addr         = mem_addr_q;
    assign mem_wdata        = mem_wdata_q;
endmodule

// File: tb/tb_l1_bus_sequencer.sv
// tb_l1_bus_sequencer: directed scenario tasks for the L1 bus sequencer; memory returns addr[7:0]^0x5A.
module tb_l1_bus_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        read_line_req = 1'b0, read_req = 1'b0, write_through_req = 1'b0;
    logic [23:0] bus_pa = '0, dma_addr = '0;
    logic [7:0]  bus_wdata = '0, dma_wdata = '0;
    logic        dma_req = 1'b0, dma_we = 1'b0, mem_rdy = 1'b0, mem_err = 1'b0;
    logic [7:0]  bus_rdata, dma_rdata, mem_wdata, mem_rdata;
    logic [7:0]  addr_count;
    logic        line_write, bus_trans_finish, bus_error, dma_ack, mem_cs, mem_we;
    logic [23:0] mem_addr;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;
    assign mem_rdata = mem_addr[7:0] ^ 8'h5A;

    l1_bus_sequencer #(.ADDR_WIDTH(24), .LINE_WID(7), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .read_line_req(read_line_req), .read_req(read_req), .write_through_req(write_through_req),
        .bus_pa(bus_pa), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .addr_count(addr_count), .line_write(line_write),
        .bus_trans_finish(bus_trans_finish), .bus_error(bus_error),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rdy(mem_rdy), .mem_err(mem_err)
    );

    task automatic do_reset();
        rst = 1'b1;
        {read_line_req, read_req, write_through_req, dma_req, dma_we, mem_rdy, mem_err} = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        read_req = 1'b1;
        bus_pa = 24'h000033;
        mem_rdy = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_cs, mem_we, line_write, bus_trans_finish, bus_error, dma_ack} !== 6'b0) begin
            failures++;
            $display("FAIL reset_strobes: got %b, expected 000000", {mem_cs, mem_we, line_write, bus_trans_finish, bus_error, dma_ack});
        end
        checks++;
        if ({addr_count, bus_rdata, dma_rdata} !== 24'h0) begin
            failures++;
            $display("FAIL reset_regs: got %h, expected 000000", {addr_count, bus_rdata, dma_rdata});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_cs !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_cycle_cs: got %b, expected 0", mem_cs);
        end
        @(negedge clk);
        checks++;
        if (mem_cs !== 1'b1 || mem_addr !== 24'h000033) begin
            failures++;
            $display("FAIL reset_first_access: got cs=%b addr=%h, expected cs=1 addr=000033", mem_cs, mem_addr);
        end
        read_req = 1'b0;
    endtask

    task automatic test_line_fill();
        int n = 0, fin = 0, errs = 0, extra = 0;
        bit done = 0;
        do_reset();
        bus_pa = 24'h012345;
        mem_rdy = 1'b1;
        read_line_req = 1'b1;
        for (int c = 0; c < 2000 && !done; c++) begin
            @(negedge clk);
            if (line_write) begin
                checks++;
                if (addr_count !== n[7:0] || mem_addr !== {16'h0123, n[7:0]} || bus_rdata !== (n[7:0] ^ 8'h5A)) begin
                    failures++;
                    $display("FAIL line_fill_beat%0d: got cnt=%h addr=%h data=%h, expected cnt=%h addr=%h data=%h",
                             n, addr_count, mem_addr, bus_rdata, n[7:0], {16'h0123, n[7:0]}, n[7:0] ^ 8'h5A);
                end
                n++;
            end
            if (bus_error) errs++;
            if (bus_trans_finish) begin
                fin++;
                done = 1;
                read_line_req = 1'b0;
            end
        end
        repeat (4) begin
            @(negedge clk);
            if (bus_trans_finish || line_write || mem_cs) extra++;
        end
        checks++;
        if (n != 256 || fin != 1 || errs != 0 || extra != 0) begin
            failures++;
            $display("FAIL line_fill_totals: got writes=%0d finish=%0d err=%0d extra=%0d, expected 256 1 0 0", n, fin, errs, extra);
        end
    endtask

    task automatic test_write_through();
        do_reset();
        bus_pa = 24'h000010;
        bus_wdata = 8'hA5;
        mem_rdy = 1'b1;
        write_through_req = 1'b1;
        for (int c = 0; c < 20 && !mem_cs; c++) @(negedge clk);
        checks++;
        if (mem_cs !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 24'h000010 || mem_wdata !== 8'hA5) begin
            failures++;
            $display("FAIL write_through_bus: got cs=%b we=%b addr=%h wdata=%h, expected 1 1 000010 a5", mem_cs, mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk);
        checks++;
        if (bus_trans_finish !== 1'b1 || mem_cs !== 1'b0) begin
            failures++;
            $display("FAIL write_through_finish: got fin=%b cs=%b, expected fin=1 cs=0", bus_trans_finish, mem_cs);
        end
        write_through_req = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_trans_finish !== 1'b0) begin
            failures++;
            $display("FAIL write_through_single_pulse: got %b, expected 0", bus_trans_finish);
        end
    endtask

    task automatic test_contention();
        string       ord;
        bit          got;
        logic        first_we;
        logic [23:0] first_addr;
        logic [7:0]  first_wd;
        do_reset();
        mem_rdy = 1'b1;
        for (int r = 0; r < 2; r++) begin
            ord = "";
            got = 0;
            first_we = 1'b0;
            first_addr = '0;
            first_wd = '0;
            bus_pa = 24'h000077;
            dma_addr = 24'h000042;
            dma_we = (r == 1);
            dma_wdata = 8'h3C;
            read_req = 1'b1;
            dma_req = 1'b1;
            for (int c = 0; c < 100 && (read_req || dma_req); c++) begin
                @(negedge clk);
                if (mem_cs && !got) begin
                    got = 1;
                    first_we = mem_we;
                    first_addr = mem_addr;
                    first_wd = mem_wdata;
                end
                if (bus_trans_finish) begin
                    ord = {ord, "C"};
                    read_req = 1'b0;
                    checks++;
                    if (bus_rdata !== 8'h2D) begin
                        failures++;
                        $display("FAIL contention_cache_rdata%0d: got %h, expected 2d", r, bus_rdata);
                    end
                end
                if (dma_ack) begin
                    ord = {ord, "D"};
                    dma_req = 1'b0;
                    if (r == 0) begin
                        checks++;
                        if (dma_rdata !== 8'h18) begin
                            failures++;
                            $display("FAIL contention_dma_rdata: got %h, expected 18", dma_rdata);
                        end
                    end
                end
            end
            checks++;
            if (ord != (r == 0 ? "CD" : "DC")) begin
                failures++;
                $display("FAIL contention_order%0d: got %s, expected %s", r, ord, r == 0 ? "CD" : "DC");
            end
            checks++;
            if (r == 0 && (first_addr !== 24'h000077 || first_we !== 1'b0)) begin
                failures++;
                $display("FAIL contention_first_cache: got addr=%h we=%b, expected 000077 0", first_addr, first_we);
            end else if (r == 1 && (first_addr !== 24'h000042 || first_we !== 1'b1 || first_wd !== 8'h3C)) begin
                failures++;
                $display("FAIL contention_first_dma: got addr=%h we=%b wd=%h, expected 000042 1 3c", first_addr, first_we, first_wd);
            end
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_fault();
        int  lw = 0, fin = 0, be = 0;
        bit  done = 0;
        do_reset();
        bus_pa = 24'h012345;
        mem_rdy = 1'b1;
        read_line_req = 1'b1;
        for (int c = 0; c < 500 && !done; c++) begin
            @(negedge clk);
            if (line_write) lw++;
            if (bus_trans_finish) fin++;
            if (bus_error) begin
                be++;
                done = 1;
                read_line_req = 1'b0;
                mem_err = 1'b0;
            end else if (mem_cs && mem_addr[7:0] == 8'd37) mem_err = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (bus_error !== 1'b0 || mem_cs !== 1'b0 || line_write !== 1'b0) begin
            failures++;
            $display("FAIL fault_idle_after: got err=%b cs=%b lw=%b, expected 0 0 0", bus_error, mem_cs, line_write);
        end
        repeat (4) begin
            @(negedge clk);
            if (bus_error) be++;
            if (bus_trans_finish) fin++;
        end
        checks++;
        if (be != 1 || fin != 0 || lw != 37) begin
            failures++;
            $display("FAIL fault_totals: got err=%0d fin=%0d writes=%0d, expected 1 0 37", be, fin, lw);
        end
    endtask

    task automatic test_timeout();
        int k = 0;
        do_reset();
        bus_pa = 24'h000055;
        read_req = 1'b1;
        for (int c = 0; c < 20 && !mem_cs; c++) @(negedge clk);
        checks++;
        if (mem_cs !== 1'b1) begin
            failures++;
            $display("FAIL timeout_cs_rise: got %b, expected 1", mem_cs);
        end
`ifdef L1_BUS_TIMEOUT_EN
        for (k = 0; k < 20 && !bus_error; k++) @(negedge clk);
        checks++;
        if (k != 4 || bus_error !== 1'b1) begin
            failures++;
            $display("FAIL timeout_latency: got %0d cycles err=%b, expected 4 cycles err=1", k, bus_error);
        end
`else
        repeat (1000) begin
            @(negedge clk);
            if (bus_error) k++;
        end
        checks++;
        if (k != 0 || mem_cs !== 1'b1) begin
            failures++;
            $display("FAIL timeout_disabled_wait: got errors=%0d cs=%b, expected 0 1", k, mem_cs);
        end
        mem_err = 1'b1;
        @(negedge clk);
        mem_err = 1'b0;
        checks++;
        if (bus_error !== 1'b1) begin
            failures++;
            $display("FAIL timeout_disabled_err: got %b, expected 1", bus_error);
        end
`endif
        read_req = 1'b0;
    endtask

    task automatic test_reset_mid_fill();
        do_reset();
        bus_pa = 24'h012345;
        mem_rdy = 1'b1;
        read_line_req = 1'b1;
        for (int c = 0; c < 1000 && !(line_write && addr_count == 8'd100); c++) @(negedge clk);
        checks++;
        if (line_write !== 1'b1 || addr_count !== 8'd100) begin
            failures++;
            $display("FAIL mid_fill_reach: got lw=%b cnt=%0d, expected 1 100", line_write, addr_count);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({mem_cs, mem_we, line_write, bus_trans_finish, bus_error, dma_ack} !== 6'b0 ||
            addr_count !== 8'h0 || bus_rdata !== 8'h0 || dma_rdata !== 8'h0) begin
            failures++;
            $display("FAIL mid_fill_async_clear: got strobes=%b cnt=%h rd=%h drd=%h, expected all zero",
                     {mem_cs, mem_we, line_write, bus_trans_finish, bus_error, dma_ack}, addr_count, bus_rdata, dma_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_cs !== 1'b0) begin
            failures++;
            $display("FAIL mid_fill_first_cycle_cs: got %b, expected 0", mem_cs);
        end
        for (int c = 0; c < 20 && !line_write; c++) @(negedge clk);
        checks++;
        if (line_write !== 1'b1 || addr_count !== 8'd0 || mem_addr !== 24'h012300) begin
            failures++;
            $display("FAIL mid_fill_restart: got lw=%b cnt=%0d addr=%h, expected 1 0 012300", line_write, addr_count, mem_addr);
        end
        read_line_req = 1'b0;
        do_reset();
    endtask

    initial begin
        test_reset();
        test_line_fill();
        test_write_through();
        test_contention();
        test_fault();
        test_timeout();
        test_reset_mid_fill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/l1_bus_sequencer.md
L1_BUS_SEQUENCER -- requirements
Module: l1_bus_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 24, physical address width.
REQ-002 SHALL have parameter LINE_WID, default 7; a line is 2^(LINE_WID+1) = 256 bytes and addr_count is LINE_WID+1 bits.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum wait in cycles for mem_rdy per beat.
REQ-004 clk  in  1  clock; rst  in  1  reset, asynchronous, active-high.
REQ-005 read_line_req / read_req / write_through_req  in  1 each  cache requests, level, held until bus_trans_finish or bus_error.
REQ-006 bus_pa  in  ADDR_WIDTH  cache address; bus_wdata  in  8  cache write byte; bus_rdata  out  8  byte returned to cache.
REQ-007 addr_count  out  LINE_WID+1  fill byte index; line_write  out  1  cache write strobe; bus_trans_finish  out  1  done pulse; bus_error  out  1  fault pulse.
REQ-008 dma_req  in  1; dma_we  in  1; dma_addr  in  ADDR_WIDTH; dma_wdata  in  8; dma_rdata  out  8; dma_ack  out  1; these form the second-requester single-byte port.
REQ-009 mem_cs  out  1; mem_we  out  1; mem_addr  out  ADDR_WIDTH; mem_wdata  out  8; mem_rdata  in  8; mem_rdy  in  1; mem_err  in  1; these form the external byte bus.

Function
REQ-010 SHALL use states IDLE, GRANT, LINE_RD, LINE_WR, SINGLE, DONE, ERR.
- IDLE -> GRANT when any request is pending.
- GRANT chooses the owner via the arbiter, then goes to LINE_RD or SINGLE.
REQ-011 Cache request priority when several are pending:
- read_line_req before read_req, and read_req before write_through_req.
- The cache as a whole competes with dma_req through 2-way round-robin.
- The winner of a contested grant becomes the lower-priority requester for the next contest.
- An uncontested grant leaves the priority unchanged.
REQ-012 LINE_RD beat:
- addr_count is cleared on entry.
- mem_addr = {bus_pa[ADDR_WIDTH-1:LINE_WID+1], addr_count}, with mem_cs=1 and mem_we=0, until mem_rdy.
- On mem_rdy, mem_rdata is registered into bus_rdata and the FSM goes to LINE_WR.
REQ-013 LINE_WR lasts one cycle:
- line_write=1 while addr_count and bus_rdata are stable.
- addr_count then increments.
- If addr_count was all-ones, the FSM goes to DONE with no wrap back into LINE_RD; otherwise it returns to LINE_RD.
REQ-014 SINGLE serves a cache read, cache write or DMA byte:
- mem_addr = bus_pa or dma_addr; mem_we = write_through_req or dma_we; mem_wdata = bus_wdata or dma_wdata.
- On mem_rdy, mem_rdata is registered into bus_rdata (cache) or dma_rdata (DMA), and the FSM goes to DONE.
REQ-015 DONE lasts one cycle:
- bus_trans_finish=1 for a cache owner; dma_ack=1 for a DMA owner.
- Next state is IDLE. A request still asserted in that IDLE cycle is re-arbitrated; no request is double-served within the DONE cycle itself.
REQ-016 mem_err while mem_cs=1 SHALL go to ERR:
- ERR is one cycle; bus_error=1 if the owner is the cache, dma_ack=1 if the owner is DMA.
- The FSM then returns to IDLE, and any partial line fill is abandoned.
REQ-017 Owner selection and address/data inputs SHALL be captured in GRANT and held until DONE or ERR; requester changes mid-transaction are ignored.
REQ-018 Outside LINE_RD and SINGLE, mem_cs SHALL be 0 and mem_addr/mem_wdata hold their last values; line_write is 1 only in LINE_WR.

Reset
REQ-019 On rst, regardless of transaction in flight:
- state = IDLE, addr_count = 0, bus_rdata = dma_rdata = 0.
- All strobes and mem_cs/mem_we = 0.
- Round-robin pointer favours the cache.
REQ-020 No memory access SHALL be issued in the first cycle after rst deasserts.

Configuration
REQ-021 Macro L1_BUS_TIMEOUT_EN defined:
- A per-beat wait counter clears on mem_cs assertion and on each mem_rdy.
- When it reaches TIMEOUT with mem_rdy=0, the FSM goes to ERR exactly as for mem_err.
REQ-022 Macro L1_BUS_TIMEOUT_EN undefined: no counter exists and the FSM waits indefinitely for mem_rdy or mem_err.

Structure
REQ-023 Package l1_bus_pkg SHALL hold the state encoding, owner encoding (OWN_CACHE, OWN_DMA) and the default ADDR_WIDTH/LINE_WID constants.
REQ-024 Arbitration SHALL be the sub-module l1_bus_rr_arb:
- Inputs: 2 request bits and the update strobe.
- Output: one-hot grant and the round-robin pointer register.

Verification
REQ-025 Line fill: read_line_req with bus_pa=0x012345 and mem_rdy every cycle gives:
- 256 line_write pulses at mem_addr 0x012300..0x0123FF, with addr_count 0..255;
- then one bus_trans_finish pulse.
REQ-026 Write-through: write_through_req with bus_pa=0x000010 and bus_wdata=0xA5 gives mem_we=1, mem_addr=0x000010, mem_wdata=0xA5, then one bus_trans_finish.
REQ-027 Contention: dma_req and read_req asserted together from reset gives:
- cache served first, DMA second;
- on re-assertion of both, DMA is served first.
REQ-028 Fault: mem_err at beat 37 of a line fill gives one bus_error pulse, no bus_trans_finish, and state IDLE the next cycle.
REQ-029 Timeout: with L1_BUS_TIMEOUT_EN, TIMEOUT=4 and mem_rdy held 0, bus_error pulses 4 cycles after mem_cs rises; without the macro, no bus_error after 1000 cycles.
REQ-030 Reset mid-fill: rst at beat 100 clears all outputs immediately; a fresh read_line_req afterwards restarts at addr_count=0.
